// File: rtl/hit_address_sequencer.sv
// Multi-channel hit address generator: per run, each channel emits NHITS (SSID, hitInfo)
// pairs under valid/ready handshake. Define RANDOM_MODE_EN to enable LFSR-based SSIDs.
module hit_address_sequencer #(
    parameter int          SSIDBITS  = 12,
    parameter int          HITBITS   = 8,
    parameter int          NCHANNELS = 4,
    parameter int          NHITS     = 256,
    parameter logic [31:0] SEED      = 32'hACE1_2468
) (
    input  logic                          clock,
    input  logic                          clearMemory,
    input  logic                          start,
    input  logic                          mode,
    input  logic [NCHANNELS-1:0]          storageReady,
    output logic [NCHANNELS-1:0]          newAddress,
    output logic [NCHANNELS*SSIDBITS-1:0] SSID,
    output logic [NCHANNELS*HITBITS-1:0]  hitInfo,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   totalCount
);

    localparam int             CW       = $clog2(NHITS + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(NHITS - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(NHITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                              state_q, state_d;
    logic [NCHANNELS-1:0]                valid_q, valid_d;
    logic [NCHANNELS-1:0][SSIDBITS-1:0]  ssid_q, ssid_d;
    logic [NCHANNELS-1:0][SSIDBITS-1:0]  ssid_first_s, ssid_next_s;
    logic [NCHANNELS-1:0][HITBITS-1:0]   hit_q, hit_d;
    logic [NCHANNELS-1:0][CW-1:0]        cnt_q, cnt_d;
    logic [15:0]                         total_q, total_d, xfer_sum_s;
    logic [NCHANNELS-1:0]                xfer_s, fin_s;

`ifdef RANDOM_MODE_EN
    logic                                rand_q, rand_d;
    logic [NCHANNELS-1:0][31:0]          lfsr_q, lfsr_d, lfsr_next_s, seed_s;

    // Right-shifting Galois LFSR, polynomial x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    // Per-channel seed, LFSR advance and SSID candidates for both modes.
    always_comb begin
        seed_s       = '0;
        lfsr_next_s  = '0;
        ssid_first_s = '0;
        ssid_next_s  = '0;
        for (int c = 0; c < NCHANNELS; c++) begin
            seed_s[c]      = SEED ^ 32'(c);
            lfsr_next_s[c] = lfsr_step(lfsr_q[c]);
            if (mode) begin
                ssid_first_s[c] = seed_s[c][SSIDBITS-1:0];
            end else begin
                ssid_first_s[c] = SSIDBITS'(c);
            end
            if (rand_q) begin
                ssid_next_s[c] = lfsr_next_s[c][SSIDBITS-1:0];
            end else begin
                ssid_next_s[c] = ssid_q[c] + SSIDBITS'(NCHANNELS);
            end
        end
    end
`else
    logic unused_mode_s;
    assign unused_mode_s = mode;

    // Sequential-only SSID candidates.
    always_comb begin
        ssid_first_s = '0;
        ssid_next_s  = '0;
        for (int c = 0; c < NCHANNELS; c++) begin
            ssid_first_s[c] = SSIDBITS'(c);
            ssid_next_s[c]  = ssid_q[c] + SSIDBITS'(NCHANNELS);
        end
    end
`endif

    // Handshake decode: transfers, finished channels and transfer popcount.
    always_comb begin
        xfer_s     = valid_q & storageReady & {NCHANNELS{state_q == S_RUN}};
        fin_s      = '0;
        xfer_sum_s = 16'd0;
        for (int c = 0; c < NCHANNELS; c++) begin
            fin_s[c]   = (cnt_q[c] == FULL_CNT);
            xfer_sum_s = xfer_sum_s + 16'(xfer_s[c]);
        end
    end

    // Next-state logic for the FSM and all per-channel datapath registers.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ssid_d  = ssid_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
        total_d = total_q;
`ifdef RANDOM_MODE_EN
        rand_d  = rand_q;
        lfsr_d  = lfsr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    valid_d = '1;
                    ssid_d  = ssid_first_s;
                    hit_d   = '0;
                    cnt_d   = '0;
                    total_d = 16'd0;
`ifdef RANDOM_MODE_EN
                    rand_d  = mode;
                    lfsr_d  = seed_s;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Leave RUN only once every channel has already dropped its valid.
                if (&fin_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                    total_d = total_q + xfer_sum_s;
                    for (int c = 0; c < NCHANNELS; c++) begin
                        if (xfer_s[c]) begin
                            cnt_d[c] = cnt_q[c] + CW'(1);
`ifdef RANDOM_MODE_EN
                            lfsr_d[c] = lfsr_next_s[c];
`endif
                            if (cnt_q[c] == LAST_CNT) begin
                                valid_d[c] = 1'b0;
                            end else begin
                                ssid_d[c] = ssid_next_s[c];
                                hit_d[c]  = hit_q[c] + HITBITS'(1);
                            end
                        end else begin
                            cnt_d[c] = cnt_q[c];
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; clearMemory wins over everything.
    always_ff @(posedge clock) begin
        if (clearMemory) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            ssid_q  <= '0;
            hit_q   <= '0;
            cnt_q   <= '0;
            total_q <= 16'd0;
`ifdef RANDOM_MODE_EN
            rand_q  <= 1'b0;
            lfsr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ssid_q  <= ssid_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
`ifdef RANDOM_MODE_EN
            rand_q  <= rand_d;
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign newAddress = valid_q;
    assign SSID       = ssid_q;
    assign hitInfo    = hit_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign totalCount = total_q;

endmodule

// File: tb/tb_hit_address_sequencer.sv
// Self-checking bench for hit_address_sequencer against a count-based reference model.
module tb_hit_address_sequencer;

    localparam int          SB   = 5;
    localparam int          HB   = 3;
    localparam int          NC   = 4;
    localparam int          NH   = 12;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam int          W    = 2 + 16 + NC + NC*SB + NC*HB;

    logic              clock = 1'b0;
    logic              clearMemory, start, mode;
    logic [NC-1:0]     storageReady;
    logic [NC-1:0]     newAddress;
    logic [NC*SB-1:0]  SSID;
    logic [NC*HB-1:0]  hitInfo;
    logic              busy, done;
    logic [15:0]       totalCount;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: run phase (0 idle, 1 run, 2 done), per-channel transfer counts.
    int m_phase;
    int m_k [NC];
    int m_total;
    bit m_shown;
    bit m_rand;

    hit_address_sequencer #(
        .SSIDBITS(SB), .HITBITS(HB), .NCHANNELS(NC), .NHITS(NH), .SEED(SEED)
    ) dut (
        .clock(clock), .clearMemory(clearMemory), .start(start), .mode(mode),
        .storageReady(storageReady), .newAddress(newAddress), .SSID(SSID),
        .hitInfo(hitInfo), .busy(busy), .done(done), .totalCount(totalCount)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_lfsr(input logic [31:0] s, input int n);
        logic [31:0] v = s;
        for (int i = 0; i < n; i++) begin
            if (v[0]) v = (v >> 1) ^ 32'h8020_0003;
            else      v = v >> 1;
        end
        return v;
    endfunction

    function automatic int shown_k(input int c);
        return (m_k[c] < NH) ? m_k[c] : NH - 1;
    endfunction

    function automatic logic [W-1:0] exp_all();
        logic [NC-1:0]    na = '0;
        logic [NC*SB-1:0] ss = '0;
        logic [NC*HB-1:0] hi = '0;
        logic [31:0]      v;
        for (int c = 0; c < NC; c++) begin
            na[c] = (m_phase == 1) && (m_k[c] < NH);
            if (m_shown) begin
                if (m_rand) begin
                    v = ref_lfsr(SEED ^ 32'(c), shown_k(c));
                    ss[c*SB +: SB] = v[SB-1:0];
                end else begin
                    ss[c*SB +: SB] = SB'((c + shown_k(c) * NC) % (1 << SB));
                end
                hi[c*HB +: HB] = HB'(shown_k(c) % (1 << HB));
            end
        end
        return {m_phase == 1, m_phase == 2, 16'(m_total), na, ss, hi};
    endfunction

    function automatic logic [W-1:0] act_all();
        return {busy, done, totalCount, newAddress, SSID, hitInfo};
    endfunction

    task automatic model_edge();
        bit all_fin;
        if (clearMemory) begin
            m_phase = 0; m_total = 0; m_shown = 0; m_rand = 0;
            for (int c = 0; c < NC; c++) m_k[c] = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_total = 0; m_shown = 1;
                    for (int c = 0; c < NC; c++) m_k[c] = 0;
`ifdef RANDOM_MODE_EN
                    m_rand = mode;
`else
                    m_rand = 0;
`endif
                end
                1: begin
                    all_fin = 1;
                    for (int c = 0; c < NC; c++) if (m_k[c] < NH) all_fin = 0;
                    if (all_fin) m_phase = 2;
                    else for (int c = 0; c < NC; c++)
                        if (m_k[c] < NH && storageReady[c]) begin
                            m_k[c]++; m_total++;
                        end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        clearMemory = 1'b1; start = 1'b1; mode = 1'b0; storageReady = '1;
        tick(); tick();
        n_checks++;
        if (act_all() !== {W{1'b0}}) $display("FAIL reset_outputs got=%h exp=%h", act_all(), {W{1'b0}});
        else n_pass++;
        clearMemory = 1'b0; start = 1'b0;
        tick();
        n_checks++;
        if (act_all() !== exp_all() || busy !== 1'b0) $display("FAIL reset_idle got=%h exp=%h", act_all(), exp_all());
        else n_pass++;
    endtask

    task automatic test_full_run();
        int n = 1, done_n = -1;
        logic [15:0] tot_at_done = 16'd0;
        storageReady = '1; mode = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        while (n < 40 && done_n < 0) begin
            n_checks++;
            if (act_all() !== exp_all()) $display("FAIL full_run cyc=%0d got=%h exp=%h", n, act_all(), exp_all());
            else n_pass++;
            if (done) begin done_n = n; tot_at_done = totalCount; end
            else begin tick(); n++; end
        end
        n_checks++;
        if (done_n !== NH + 2) $display("FAIL full_run_done_cycle got=%0d exp=%0d", done_n, NH + 2);
        else n_pass++;
        n_checks++;
        if (tot_at_done !== 16'(NC*NH)) $display("FAIL full_run_total got=%0d exp=%0d", tot_at_done, NC*NH);
        else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        int n = 1, done_n = -1;
        storageReady = '1; mode = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        while (n < 50 && done_n < 0) begin
            n_checks++;
            if (act_all() !== exp_all()) $display("FAIL backpressure cyc=%0d got=%h exp=%h", n, act_all(), exp_all());
            else n_pass++;
            storageReady = (n >= 4 && n <= 6) ? 4'b1011 : 4'b1111;
            if (done) done_n = n;
            else begin tick(); n++; end
        end
        n_checks++;
        if (done_n !== NH + 5) $display("FAIL backpressure_done_cycle got=%0d exp=%0d", done_n, NH + 5);
        else n_pass++;
        storageReady = '1;
        tick();
    endtask

    task automatic test_random_mode();
        int n = 0;
        logic [SB-1:0] e0, e1;
`ifdef RANDOM_MODE_EN
        e0 = 5'h08; e1 = 5'h14;
`else
        e0 = 5'h00; e1 = 5'h04;
`endif
        storageReady = '1; mode = 1'b1; start = 1'b1;
        tick(); start = 1'b0; mode = 1'b0;
        n_checks++;
        if (SSID[SB-1:0] !== e0) $display("FAIL random_first_ssid got=%h exp=%h", SSID[SB-1:0], e0);
        else n_pass++;
        tick();
        n_checks++;
        if (SSID[SB-1:0] !== e1) $display("FAIL random_second_ssid got=%h exp=%h", SSID[SB-1:0], e1);
        else n_pass++;
        while (n < 40 && !done) begin
            n_checks++;
            if (act_all() !== exp_all()) $display("FAIL random_run cyc=%0d got=%h exp=%h", n, act_all(), exp_all());
            else n_pass++;
            mode = 1'($urandom_range(0, 1));
            tick(); n++;
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL random_run_timeout got=%b exp=%b", done, 1'b1);
        else n_pass++;
        tick();
    endtask

    task automatic test_abort();
        storageReady = '1; mode = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        clearMemory = 1'b1; start = 1'b1;
        tick();
        clearMemory = 1'b0; start = 1'b0;
        n_checks++;
        if (act_all() !== {W{1'b0}}) $display("FAIL abort_outputs got=%h exp=%h", act_all(), {W{1'b0}});
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_no_done got=%b%b exp=00", done, busy);
        else n_pass++;
        start = 1'b1;
        tick(); start = 1'b0;
        n_checks++;
        if (SSID[SB +: SB] !== 5'd1 || hitInfo !== {(NC*HB){1'b0}} || act_all() !== exp_all())
            $display("FAIL abort_restart got=%h exp=%h", act_all(), exp_all());
        else n_pass++;
        for (int i = 0; i < 40 && !done; i++) tick();
        tick();
    endtask

    task automatic test_start_held();
        int done_n = -1, rise_n = -1;
        logic prev_busy = 1'b0;
        storageReady = '1; mode = 1'b0; start = 1'b1;
        for (int n = 1; n < 60 && rise_n < 0; n++) begin
            tick();
            n_checks++;
            if (act_all() !== exp_all()) $display("FAIL start_held cyc=%0d got=%h exp=%h", n, act_all(), exp_all());
            else n_pass++;
            if (done) done_n = n;
            if (busy && !prev_busy && done_n > 0) rise_n = n;
            prev_busy = busy;
        end
        n_checks++;
        if (rise_n - done_n !== 2) $display("FAIL start_held_restart got=%0d exp=%0d", rise_n - done_n, 2);
        else n_pass++;
        start = 1'b0; clearMemory = 1'b1;
        tick(); clearMemory = 1'b0;
    endtask

    task automatic test_random_traffic();
        for (int n = 0; n < 400; n++) begin
            start        = ($urandom_range(0, 7) == 0);
            mode         = 1'($urandom_range(0, 1));
            storageReady = NC'($urandom);
            clearMemory  = ($urandom_range(0, 99) == 0);
            tick();
            n_checks++;
            if (act_all() !== exp_all()) $display("FAIL random_traffic cyc=%0d got=%h exp=%h", n, act_all(), exp_all());
            else n_pass++;
        end
        clearMemory = 1'b0; start = 1'b0;
    endtask

    initial begin
        clearMemory = 1'b0; start = 1'b0; mode = 1'b0; storageReady = '0;
        m_phase = 0; m_total = 0; m_shown = 0; m_rand = 0;
        for (int c = 0; c < NC; c++) m_k[c] = 0;
        test_reset();
        test_full_run();
        test_backpressure();
        test_random_mode();
        test_abort();
        test_start_held();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
